// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter sharing one UART TX byte stream among NUM_REQ requesters.
// Grant one cycle after request; bytes pass combinationally under TX_READY backpressure; a stalled owner is released by a watchdog.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic                      CLK_BASE,
  input  logic                      RESET,
  input  logic [NUM_REQ-1:0]        REQ_VALID,
  input  logic [NUM_REQ-1:0]        REQ_LAST,
  input  logic [NUM_REQ*DATA_W-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]        REQ_READY,
  output logic [DATA_W-1:0]         TX_DATA,
  output logic                      TX_VALID,
  input  logic                      TX_READY,
  output logic [NUM_REQ-1:0]        GRANT,
  output logic                      BUSY,
  output logic                      ABORT,
  output logic [2:0]                ABORT_ID
);

  typedef enum logic {S_IDLE, S_LOCK} state_t;

  localparam bit              WDOG_EN  = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] WCNT_MAX = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_gidx, w_gidx_nxt;
  logic [2:0]       r_rr_ptr, w_rr_ptr_nxt;
  logic [2:0]       r_abort_id, w_abort_id_nxt;
  logic [CNT_W-1:0] r_wcnt, w_wcnt_nxt;
  logic             r_abort, w_abort_nxt;

  logic [NUM_REQ-1:0] w_gnt_oh;
  logic [DATA_W-1:0]  w_sel_dat;
  logic               w_sel_vld;
  logic               w_sel_last;
  logic               w_lock;
  logic               w_hs;
  logic               w_found;
  logic [2:0]         w_winner;
  int                 w_idx;

  // Owner decode as a one-hot mask keeps every select a constant index.
  always_comb begin
    w_gnt_oh  = '0;
    w_sel_dat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_gidx == 3'(i)) begin
        w_gnt_oh[i] = 1'b1;
        w_sel_dat   = REQ_DATA[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_sel_vld  = |(REQ_VALID & w_gnt_oh);
  assign w_sel_last = |(REQ_LAST & w_gnt_oh);
  assign w_lock     = (r_state == S_LOCK);
  assign w_hs       = w_lock & w_sel_vld & TX_READY;

  // Search upward from rr_ptr+1 so the previous winner is considered last.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NUM_REQ) begin
        w_idx = w_idx - NUM_REQ;
      end
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!w_found && (j == w_idx) && REQ_VALID[j]) begin
          w_found  = 1'b1;
          w_winner = 3'(j);
        end
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_gidx_nxt     = r_gidx;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_wcnt_nxt     = r_wcnt;
    w_abort_nxt    = 1'b0;
    w_abort_id_nxt = r_abort_id;
    case (r_state)
      S_IDLE: begin
        // The abort cycle is a dead cycle: no arbitration while ABORT is shown.
        if (w_found && !r_abort) begin
          w_state_nxt  = S_LOCK;
          w_gidx_nxt   = w_winner;
          w_rr_ptr_nxt = w_winner;
          w_wcnt_nxt   = '0;
        end
      end
      S_LOCK: begin
        if (w_hs) begin
          w_wcnt_nxt = '0;
          if (w_sel_last) begin
            w_state_nxt = S_IDLE;
          end
        end else if (!w_sel_vld && WDOG_EN) begin
          // Only owner silence counts; TX backpressure with data pending holds the count.
          if (r_wcnt == WCNT_MAX) begin
            w_state_nxt    = S_IDLE;
            w_abort_nxt    = 1'b1;
            w_abort_id_nxt = r_gidx;
            w_wcnt_nxt     = '0;
          end else begin
            w_wcnt_nxt = r_wcnt + CNT_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK_BASE) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_gidx     <= '0;
      r_rr_ptr   <= 3'(NUM_REQ - 1);
      r_wcnt     <= '0;
      r_abort    <= 1'b0;
      r_abort_id <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gidx     <= w_gidx_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_wcnt     <= w_wcnt_nxt;
      r_abort    <= w_abort_nxt;
      r_abort_id <= w_abort_id_nxt;
    end
  end

  assign TX_VALID  = w_lock & w_sel_vld;
  assign TX_DATA   = w_lock ? w_sel_dat : '0;
  assign REQ_READY = (w_lock & TX_READY) ? w_gnt_oh : '0;
  assign GRANT     = w_lock ? w_gnt_oh : '0;
  assign BUSY      = w_lock;
  assign ABORT     = r_abort;
  assign ABORT_ID  = r_abort_id;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus a randomized run against a cycle-level reference model.
module tb_uart_tx_arbiter;
  localparam int N  = 2;
  localparam int DW = 8;
  localparam int TO = 16;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_last, req_ready, grant;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0]   tx_data;
  logic            tx_valid, tx_ready, busy, abort;
  logic [2:0]      abort_id;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .CLK_BASE (clk),
    .RESET    (rst),
    .REQ_VALID(req_valid),
    .REQ_LAST (req_last),
    .REQ_DATA (req_data),
    .REQ_READY(req_ready),
    .TX_DATA  (tx_data),
    .TX_VALID (tx_valid),
    .TX_READY (tx_ready),
    .GRANT    (grant),
    .BUSY     (busy),
    .ABORT    (abort),
    .ABORT_ID (abort_id)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic logic bit_of(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic logic [DW-1:0] byte_of(input logic [N*DW-1:0] d, input int i);
    logic [N*DW-1:0] t;
    t = d >> (i * DW);
    return t[DW-1:0];
  endfunction

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b11; req_last = '0; req_data = 16'h2211; tx_ready = 1'b1;
    step(); step();
    sample();
    n_checks++;
    if ({tx_valid, req_ready, grant, busy, abort, abort_id, tx_data} !== 18'd0)
      $display("FAIL reset_outputs: got %h want 0", {tx_valid, req_ready, grant, busy, abort, abort_id, tx_data});
    else n_pass++;
    step(); rst = 1'b0;
    sample();
    n_checks++;
    if (grant !== 2'b00) $display("FAIL reset_release_idle: grant %b want 00", grant); else n_pass++;
    step(); sample();
    n_checks++;
    if ({grant, tx_data} !== {2'b01, 8'h11})
      $display("FAIL reset_first_winner: grant/data %b/%h want 01/11", grant, tx_data);
    else n_pass++;
  endtask

  task automatic test_single_msg();
    logic [7:0] msg [3];
    msg = '{8'h41, 8'h42, 8'h0D};
    do_reset();
    tx_ready = 1'b1; req_valid = 2'b01;
    for (int b = 0; b < 3; b++) begin
      req_data[7:0] = msg[b];
      req_last = (b == 2) ? 2'b01 : 2'b00;
      if (b == 0) begin
        sample();
        n_checks++;
        if ({grant, busy} !== 3'b000) $display("FAIL single_idle_first: grant/busy %b/%b want 00/0", grant, busy);
        else n_pass++;
        step();
      end
      sample();
      n_checks++;
      if ({grant, tx_valid, req_ready, tx_data} !== {2'b01, 1'b1, 2'b01, msg[b]})
        $display("FAIL single_byte%0d: grant %b vld %b rdy %b data %h want 01 1 01 %h",
                 b, grant, tx_valid, req_ready, tx_data, msg[b]);
      else n_pass++;
      step();
    end
    req_valid = '0; req_last = '0;
    sample();
    n_checks++;
    if ({grant, busy, tx_valid} !== 4'b0000) $display("FAIL single_release: grant %b busy %b vld %b want 0", grant, busy, tx_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int         bidx [N];
    int         owner;
    logic [1:0] exp_g;
    logic [7:0] exp_d;
    do_reset();
    tx_ready = 1'b1; req_valid = 2'b11;
    for (int i = 0; i < N; i++) bidx[i] = 0;
    for (int c = 0; c < 18; c++) begin
      for (int i = 0; i < N; i++) begin
        req_data[i*DW +: DW] = {4'(i), 4'(bidx[i])};
        req_last[i] = (bidx[i] == 1);
      end
      sample();
      owner = (c / 3) % 2;
      if (c % 3 == 0) begin exp_g = 2'b00; exp_d = 8'h00; end
      else begin exp_g = 2'b01 << owner; exp_d = {4'(owner), 4'((c % 3) - 1)}; end
      n_checks++;
      if ({grant, tx_data} !== {exp_g, exp_d})
        $display("FAIL b2b_cycle%0d: grant/data %b/%h want %b/%h", c, grant, tx_data, exp_g, exp_d);
      else n_pass++;
      for (int i = 0; i < N; i++) if (req_ready[i] && req_valid[i]) bidx[i] = 1 - bidx[i];
      step();
    end
  endtask

  task automatic test_backpressure();
    int n_abort = 0;
    int n_bad = 0;
    do_reset();
    req_valid = 2'b01; req_data = 16'h0055; req_last = '0; tx_ready = 1'b0;
    step();
    repeat (5000) begin
      sample();
      if (abort) n_abort++;
      if (grant !== 2'b01 || tx_valid !== 1'b1 || req_ready !== 2'b00) n_bad++;
      step();
    end
    n_checks++;
    if (n_abort !== 0) $display("FAIL bp_no_abort: %0d abort pulses want 0", n_abort); else n_pass++;
    n_checks++;
    if (n_bad !== 0) $display("FAIL bp_hold_grant: %0d bad cycles want 0", n_bad); else n_pass++;
    tx_ready = 1'b1;
    sample();
    n_checks++;
    if ({grant, req_ready, tx_data} !== {2'b01, 2'b01, 8'h55})
      $display("FAIL bp_resume: grant %b rdy %b data %h want 01 01 55", grant, req_ready, tx_data);
    else n_pass++;
    step(); req_data = 16'h0056; req_last = 2'b01;
    sample();
    n_checks++;
    if ({grant, tx_data} !== {2'b01, 8'h56}) $display("FAIL bp_last: grant/data %b/%h want 01/56", grant, tx_data);
    else n_pass++;
    step(); req_valid = '0; req_last = '0;
    sample();
    n_checks++;
    if ({busy, abort} !== 2'b00) $display("FAIL bp_done: busy/abort %b/%b want 0/0", busy, abort); else n_pass++;
  endtask

  task automatic test_timeout();
    int n_bad = 0;
    do_reset();
    tx_ready = 1'b1; req_valid = 2'b10; req_data = 16'hA100; req_last = '0;
    sample(); step(); sample();
    n_checks++;
    if ({grant, req_ready, tx_data} !== {2'b10, 2'b10, 8'hA1})
      $display("FAIL to_grant1: grant %b rdy %b data %h want 10 10 a1", grant, req_ready, tx_data);
    else n_pass++;
    step(); req_valid = 2'b01; req_data = 16'h0033;
    for (int s = 0; s < TO; s++) begin
      sample();
      if (abort !== 1'b0 || grant !== 2'b10 || req_ready !== 2'b10 || tx_valid !== 1'b0) n_bad++;
      step();
    end
    n_checks++;
    if (n_bad !== 0) $display("FAIL to_stall_window: %0d bad cycles want 0", n_bad); else n_pass++;
    sample();
    n_checks++;
    if ({abort, abort_id, grant, busy} !== {1'b1, 3'd1, 2'b00, 1'b0})
      $display("FAIL to_abort_pulse: abort %b id %0d grant %b busy %b want 1 1 00 0", abort, abort_id, grant, busy);
    else n_pass++;
    step(); sample();
    n_checks++;
    if ({abort, abort_id, grant} !== {1'b0, 3'd1, 2'b00})
      $display("FAIL to_after_pulse: abort %b id %0d grant %b want 0 1 00", abort, abort_id, grant);
    else n_pass++;
    step(); sample();
    n_checks++;
    if ({grant, tx_data} !== {2'b01, 8'h33}) $display("FAIL to_regrant: grant/data %b/%h want 01/33", grant, tx_data);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    tx_ready = 1'b1; req_valid = 2'b01; req_data = 16'h0061; req_last = '0;
    step(); sample();
    n_checks++;
    if (grant !== 2'b01) $display("FAIL rm_grant: grant %b want 01", grant); else n_pass++;
    step(); req_data = 16'h0062; rst = 1'b1;
    sample();
    n_checks++;
    if (busy !== 1'b1) $display("FAIL rm_before_edge: busy %b want 1", busy); else n_pass++;
    step(); rst = 1'b0; req_valid = 2'b11;
    sample();
    n_checks++;
    if ({busy, abort, grant} !== 4'b0000) $display("FAIL rm_cleared: busy %b abort %b grant %b want 0", busy, abort, grant);
    else n_pass++;
    step(); sample();
    n_checks++;
    if ({grant, abort} !== {2'b01, 1'b0}) $display("FAIL rm_regrant: grant %b abort %b want 01 0", grant, abort);
    else n_pass++;
  endtask

  task automatic test_random();
    int         m_owner, m_last, m_stall, m_abort_id, w;
    bit         m_pulse, new_pulse, e_busy;
    int         rem [N];
    int         drop [N];
    bit         acc [N];
    logic [7:0] dat [N];
    logic       v, e_tv;
    logic [N-1:0]  e_grant, e_ready;
    logic [DW-1:0] e_data;
    logic [17:0]   exp_v, obs_v;
    do_reset();
    m_owner = -1; m_last = N - 1; m_stall = 0; m_pulse = 0; m_abort_id = 0;
    for (int i = 0; i < N; i++) begin
      rem[i] = $urandom_range(1, 4); drop[i] = 0; acc[i] = 0; dat[i] = 8'($urandom);
    end
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          rem[i]--;
          if (rem[i] == 0) rem[i] = $urandom_range(1, 4);
          dat[i] = 8'($urandom);
        end
        if (drop[i] > 0) begin drop[i]--; v = 1'b0; end
        else if (m_owner == i) begin
          if ($urandom_range(0, 11) == 0) begin drop[i] = $urandom_range(1, 24); v = 1'b0; end
          else v = 1'b1;
        end
        else if (req_valid[i] && !acc[i]) v = 1'b1;
        else v = ($urandom_range(0, 2) == 0);
        req_valid[i] = v;
        req_last[i] = (rem[i] == 1);
        req_data[i*DW +: DW] = dat[i];
      end
      tx_ready = ($urandom_range(0, 3) != 0);
      sample();
      e_busy = (m_owner >= 0);
      e_grant = e_busy ? (N'(1) << m_owner) : '0;
      e_tv = e_busy ? bit_of(req_valid, m_owner) : 1'b0;
      e_data = e_busy ? byte_of(req_data, m_owner) : '0;
      e_ready = (e_busy && tx_ready) ? e_grant : '0;
      exp_v = {e_tv, e_data, e_ready, e_grant, e_busy, m_pulse, 3'(m_abort_id)};
      obs_v = {tx_valid, tx_data, req_ready, grant, busy, abort, abort_id};
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL random_cycle%0d: outputs %h want %h", c, obs_v, exp_v);
      else n_pass++;
      for (int i = 0; i < N; i++) acc[i] = (m_owner == i) && req_valid[i] && tx_ready;
      new_pulse = 0;
      if (m_owner < 0) begin
        if (!m_pulse) begin
          for (int k = 1; k <= N; k++) begin
            w = (m_last + k) % N;
            if (m_owner < 0 && bit_of(req_valid, w)) begin m_owner = w; m_last = w; m_stall = 0; end
          end
        end
      end else if (bit_of(req_valid, m_owner) && tx_ready) begin
        m_stall = 0;
        if (bit_of(req_last, m_owner)) m_owner = -1;
      end else if (!bit_of(req_valid, m_owner)) begin
        m_stall++;
        if (m_stall == TO) begin new_pulse = 1; m_abort_id = m_owner; m_owner = -1; m_stall = 0; end
      end
      m_pulse = new_pulse;
      step();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b0;
    test_reset();
    test_single_msg();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
